// File: rtl/mips_pkg.sv
// Shared encodings and constants for the EX-stage HI/LO multiply/divide unit.
package mips_pkg;

    // Operand width and number of quotient bits produced by the divider
    localparam int DIV_BITS = 32;

    // Mul/div-class operation codes carried on MdOpE; 6 and 7 are no-ops
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    // Unit states; the divide-iteration state is MD_DIV_RUN because the
    // name MD_DIV already belongs to the opcode above
    typedef enum logic [1:0] {
        MD_IDLE    = 2'd0,
        MD_MUL     = 2'd1,
        MD_DIV_RUN = 2'd2,
        MD_FIX     = 2'd3
    } md_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module div_step
    import mips_pkg::*;
(
    input  logic [DIV_BITS:0]   rem_in,
    input  logic                dividend_bit,
    input  logic [DIV_BITS-1:0] divisor,
    output logic [DIV_BITS:0]   rem_next,
    output logic                q_bit
);
    logic [DIV_BITS:0] trial;
    logic [DIV_BITS:0] divisor_ext;

    // A set top remainder bit means the shifted value certainly exceeds the
    // divisor, so it forces a quotient 1 (never happens while rem < divisor)
    always_comb begin
        trial       = {rem_in[DIV_BITS-1:0], dividend_bit};
        divisor_ext = {1'b0, divisor};
        q_bit       = rem_in[DIV_BITS] | (trial >= divisor_ext);
        rem_next    = q_bit ? (trial - divisor_ext) : trial;
    end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage HI/LO unit: multi-cycle MULT/MULTU, 32-step iterative DIV/DIVU,
// single-cycle MTHI/MTLO, and the BusyE stall request for the hazard unit.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StartE,
    input  logic [2:0]  MdOpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    output logic        BusyE,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut
);
    localparam int W     = DIV_BITS;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(W - 1);

    md_state_t        state_reg, state_next;
    logic [W-1:0]     hi_reg, hi_next;
    logic [W-1:0]     lo_reg, lo_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    // opa: multiplicand, or dividend magnitude that shifts into the quotient
    logic [W-1:0]     opa_reg, opa_next;
    // opb: multiplier, or divisor magnitude
    logic [W-1:0]     opb_reg, opb_next;
    logic [W:0]       rem_reg, rem_next;
    logic             mul_signed_reg, mul_signed_next;
    logic             a_neg_reg, a_neg_next;
    logic             b_neg_reg, b_neg_next;
    logic             div_zero_reg, div_zero_next;

    logic [2*W-1:0]   mul_a_ext, mul_b_ext, product;
    logic [W:0]       step_rem;
    logic             step_q;

    // Low 2W bits of the extended product are correct for both signed and unsigned
    assign mul_a_ext = mul_signed_reg ? {{W{opa_reg[W-1]}}, opa_reg} : {{W{1'b0}}, opa_reg};
    assign mul_b_ext = mul_signed_reg ? {{W{opb_reg[W-1]}}, opb_reg} : {{W{1'b0}}, opb_reg};
    assign product   = mul_a_ext * mul_b_ext;

    div_step u_div_step (
        .rem_in       (rem_reg),
        .dividend_bit (opa_reg[W-1]),
        .divisor      (opb_reg),
        .rem_next     (step_rem),
        .q_bit        (step_q)
    );

    // Ops 0..3 (MdOpE[2]==0) are the multi-cycle class that must stall in the acceptance cycle
    assign BusyE = (state_reg != MD_IDLE) | (StartE & ~MdOpE[2]);
    assign HiOut = hi_reg;
    assign LoOut = lo_reg;

    // Next-state and datapath updates; starts outside IDLE are ignored
    always_comb begin
        state_next      = state_reg;
        hi_next         = hi_reg;
        lo_next         = lo_reg;
        cnt_next        = cnt_reg;
        opa_next        = opa_reg;
        opb_next        = opb_reg;
        rem_next        = rem_reg;
        mul_signed_next = mul_signed_reg;
        a_neg_next      = a_neg_reg;
        b_neg_next      = b_neg_reg;
        div_zero_next   = div_zero_reg;
        case (state_reg)
            MD_IDLE: begin
                if (StartE) begin
                    case (MdOpE)
                        MD_MULT, MD_MULTU: begin
                            opa_next        = SrcAE;
                            opb_next        = SrcBE;
                            mul_signed_next = (MdOpE == MD_MULT);
                            cnt_next        = MUL_CNT_INIT;
                            state_next      = MD_MUL;
                        end
                        MD_DIV, MD_DIVU: begin
                            a_neg_next    = (MdOpE == MD_DIV) & SrcAE[W-1];
                            b_neg_next    = (MdOpE == MD_DIV) & SrcBE[W-1];
                            opa_next      = a_neg_next ? -SrcAE : SrcAE;
                            opb_next      = b_neg_next ? -SrcBE : SrcBE;
                            div_zero_next = (SrcBE == '0);
                            rem_next      = '0;
                            cnt_next      = DIV_CNT_INIT;
                            state_next    = MD_DIV_RUN;
                        end
                        MD_MTHI: hi_next = SrcAE;
                        MD_MTLO: lo_next = SrcAE;
                        default: ;
                    endcase
                end
            end
            MD_MUL: begin
                if (cnt_reg == '0) begin
                    {hi_next, lo_next} = product;
                    state_next         = MD_IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            MD_DIV_RUN: begin
                rem_next = step_rem;
                opa_next = {opa_reg[W-2:0], step_q};
                if (cnt_reg == '0) begin
                    state_next = MD_FIX;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            MD_FIX: begin
                // Divide by zero leaves rem = |dividend|, so HI restores the raw dividend
                if (div_zero_reg) begin
                    lo_next = '1;
                end else begin
                    lo_next = (a_neg_reg ^ b_neg_reg) ? -opa_reg : opa_reg;
                end
                hi_next    = a_neg_reg ? -rem_reg[W-1:0] : rem_reg[W-1:0];
                state_next = MD_IDLE;
            end
            default: state_next = MD_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset discarding any partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= MD_IDLE;
            hi_reg         <= '0;
            lo_reg         <= '0;
            cnt_reg        <= '0;
            opa_reg        <= '0;
            opb_reg        <= '0;
            rem_reg        <= '0;
            mul_signed_reg <= 1'b0;
            a_neg_reg      <= 1'b0;
            b_neg_reg      <= 1'b0;
            div_zero_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hi_reg         <= hi_next;
            lo_reg         <= lo_next;
            cnt_reg        <= cnt_next;
            opa_reg        <= opa_next;
            opb_reg        <= opb_next;
            rem_reg        <= rem_next;
            mul_signed_reg <= mul_signed_next;
            a_neg_reg      <= a_neg_next;
            b_neg_reg      <= b_neg_next;
            div_zero_reg   <= div_zero_next;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: latency-countdown reference model,
// per-cycle compare of HI/LO/BusyE, directed literal cases, random ops.
module tb_muldiv_unit;

    localparam int LAT = 3;
    localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2,
                           OP_DIVU = 3'd3, OP_MTHI = 3'd4, OP_MTLO = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        StartE;
    logic [2:0]  MdOpE;
    logic [31:0] SrcAE, SrcBE;
    logic        BusyE;
    logic [31:0] HiOut, LoOut;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Reference model state: architectural HI/LO, pending result and edges left until it lands
    logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
    int          m_left = 0;
    logic        exp_busy;

    muldiv_unit #(.MUL_LAT(LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .StartE (StartE),
        .MdOpE  (MdOpE),
        .SrcAE  (SrcAE),
        .SrcBE  (SrcBE),
        .BusyE  (BusyE),
        .HiOut  (HiOut),
        .LoOut  (LoOut)
    );

    always #5 clk = ~clk;

    // Architectural result {HI, LO} from plain arithmetic
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sq, sr;
        case (op)
            OP_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            OP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Model update on each edge
    always @(posedge clk) begin
        logic [63:0] res;
        if (rst) begin
            m_hi <= '0;
            m_lo <= '0;
            m_left <= 0;
        end else if (m_left > 0) begin
            assert (!StartE) else begin
                failures++;
                $display("FAIL start_while_busy: StartE=%0b while unit busy, required 0", StartE);
            end
            if (m_left == 1) begin
                m_hi <= r_hi;
                m_lo <= r_lo;
            end
            m_left <= m_left - 1;
        end else if (StartE) begin
            case (MdOpE)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    res = ref_md(MdOpE, SrcAE, SrcBE);
                    r_hi <= res[63:32];
                    r_lo <= res[31:0];
                    m_left <= (MdOpE < OP_DIV) ? LAT : 33;
                end
                OP_MTHI: m_hi <= SrcAE;
                OP_MTLO: m_lo <= SrcAE;
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h required %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            exp_busy = (m_left > 0) || (StartE && (MdOpE < OP_MTHI));
            chk("cyc_busy", {31'd0, BusyE}, {31'd0, exp_busy});
            chk("cyc_hi", HiOut, m_hi);
            chk("cyc_lo", LoOut, m_lo);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (m_left != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (m_left != 0) begin
            failures++;
            $display("FAIL wait_idle: model still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        $display("op=%0d a=%08h b=%08h", op, a, b);
        StartE = 1'b1;
        MdOpE  = op;
        SrcAE  = a;
        SrcBE  = b;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        drive(op, a, b);
        @(posedge clk);
        #1 StartE = 1'b0;
    endtask

    // Issue one op and count consecutive BusyE cycles starting at the acceptance cycle
    task automatic issue_count(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int nbusy);
        wait_idle();
        drive(op, a, b);
        nbusy = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (BusyE !== 1'b1) break;
            nbusy++;
            @(posedge clk);
            #1 StartE = 1'b0;
        end
        if (StartE) begin
            @(posedge clk);
            #1 StartE = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int nb;
        logic [2:0] rop;
        rst = 1'b1; StartE = 1'b0; MdOpE = '0; SrcAE = '0; SrcBE = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", HiOut, 32'h0);
        chk("reset_lo", LoOut, 32'h0);
        chk("reset_busy", {31'd0, BusyE}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        issue_count(OP_MULTU, 32'hFFFFFFFF, 32'd2, nb);
        chk("multu_busy_cycles", 32'(nb), 32'(1 + LAT));
        wait_idle();
        chk("multu_hi", HiOut, 32'h00000001);
        chk("multu_lo", LoOut, 32'hFFFFFFFE);

        do_op(OP_MULT, 32'hFFFFFFFD, 32'd7);
        wait_idle();
        chk("mult_hi", HiOut, 32'hFFFFFFFF);
        chk("mult_lo", LoOut, 32'hFFFFFFEB);

        issue_count(OP_DIV, 32'hFFFFFFF9, 32'd2, nb);
        chk("div_busy_cycles", 32'(nb), 32'd34);
        wait_idle();
        chk("div_lo", LoOut, 32'hFFFFFFFD);
        chk("div_hi", HiOut, 32'hFFFFFFFF);

        do_op(OP_DIVU, 32'd100, 32'd0);
        wait_idle();
        chk("divu_zero_lo", LoOut, 32'hFFFFFFFF);
        chk("divu_zero_hi", HiOut, 32'd100);

        do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();
        chk("div_ovf_lo", LoOut, 32'h80000000);
        chk("div_ovf_hi", HiOut, 32'h0);

        wait_idle();
        drive(OP_MTHI, 32'h12345678, 32'd0);
        @(posedge clk);
        #1;
        chk("mthi_hi", HiOut, 32'h12345678);
        chk("mthi_busy", {31'd0, BusyE}, 32'd0);
        drive(OP_MTLO, 32'hCAFEBABE, 32'd0);
        @(posedge clk);
        #1;
        chk("mtlo_lo", LoOut, 32'hCAFEBABE);
        chk("mtlo_hi_kept", HiOut, 32'h12345678);
        StartE = 1'b0;

        do_op(OP_DIVU, 32'd50, 32'd7);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        $display("reset asserted mid-divide");
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_hi", HiOut, 32'h0);
        chk("midrst_lo", LoOut, 32'h0);
        chk("midrst_busy", {31'd0, BusyE}, 32'd0);

        do_op(OP_DIVU, 32'd50, 32'd7);
        wait_idle();
        chk("divu_lo", LoOut, 32'd7);
        chk("divu_hi", HiOut, 32'd1);

        for (int i = 0; i < 80; i++) begin
            rop = 3'($urandom_range(0, 7));
            do_op(rop, rand_operand(), rand_operand());
        end
        wait_idle();
        @(negedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required finish before 2000000");
        $fatal(1, "timeout");
    end

endmodule
